// File: rtl/rvfpm_issue_pkg.sv
// rvfpm_issue_pkg: shared types, opcode/funct7 constants and the F-extension
// register-usage decoder for the rvfpm issue stage.
//   decoded_t    : legality plus which of rs1/rs2/rs3/rd are F registers
//   sb_entry_t   : one scoreboard slot {valid, rd, writes_f}
//   decode_instr : decodes a 32-bit instruction against a register-file size
package rvfpm_issue_pkg;

  localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
  localparam logic [6:0] OPC_FMADD  = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD = 7'b1001111;

  localparam logic [6:0] F7_FADD     = 7'b0000000;
  localparam logic [6:0] F7_FSUB     = 7'b0000100;
  localparam logic [6:0] F7_FMUL     = 7'b0001000;
  localparam logic [6:0] F7_FDIV     = 7'b0001100;
  localparam logic [6:0] F7_FSGNJ    = 7'b0010000;
  localparam logic [6:0] F7_FMINMAX  = 7'b0010100;
  localparam logic [6:0] F7_FSQRT    = 7'b0101100;
  localparam logic [6:0] F7_FCMP     = 7'b1010000;
  localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
  localparam logic [6:0] F7_FCVT_S_W = 7'b1101000;
  localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;  // also FCLASS
  localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;

  typedef struct packed {
    logic       legal;
    logic       rs1F;
    logic       rs2F;
    logic       rs3F;
    logic       rdF;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [4:0] rd;
  } decoded_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writes_f;
  } sb_entry_t;

  function automatic decoded_t decode_instr(input logic [31:0] ins,
                                            input int unsigned nregs);
    decoded_t d;
    d       = '0;
    d.rd    = ins[11:7];
    d.rs1   = ins[19:15];
    d.rs2   = ins[24:20];
    d.rs3   = ins[31:27];
    case (ins[6:0])
      OPC_OP_FP: begin
        d.legal = 1'b1;
        case (ins[31:25])
          F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV, F7_FSGNJ, F7_FMINMAX: begin
            d.rs1F = 1'b1;
            d.rs2F = 1'b1;
            d.rdF  = 1'b1;
          end
          F7_FSQRT: begin
            d.rs1F = 1'b1;
            d.rdF  = 1'b1;
          end
          F7_FMV_X_W, F7_FCVT_W_S: d.rs1F = 1'b1;
          F7_FCMP: begin
            d.rs1F = 1'b1;
            d.rs2F = 1'b1;
          end
          F7_FCVT_S_W, F7_FMV_W_X: d.rdF = 1'b1;
          default: d.legal = 1'b0;
        endcase
      end
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
        d.legal = 1'b1;
        d.rs1F  = 1'b1;
        d.rs2F  = 1'b1;
        d.rs3F  = 1'b1;
        d.rdF   = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    // Only indices actually used as F registers are range-checked.
    if ((d.rs1F && 32'(d.rs1) >= nregs) || (d.rs2F && 32'(d.rs2) >= nregs) ||
        (d.rs3F && 32'(d.rs3) >= nregs) || (d.rdF && 32'(d.rd) >= nregs))
      d.legal = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/rvfpm_issue_if.sv
// rvfpm_issue_if: core-side valid/ready instruction handshake and the
// rvfpm-side issue bus.
//   master : the core / rvfpm side (drives offers, observes issue)
//   slave  : the issue stage (accepts offers, drives issue)
interface rvfpm_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction_in;
  logic [31:0] data_fromXReg_in;
  logic        enable;
  logic [31:0] instruction;
  logic [31:0] data_fromXReg;

  modport master (
    output instr_valid, instruction_in, data_fromXReg_in,
    input  instr_ready, enable, instruction, data_fromXReg
  );

  modport slave (
    input  instr_valid, instruction_in, data_fromXReg_in,
    output instr_ready, enable, instruction, data_fromXReg
  );
endinterface

// File: rtl/rvfpm_issue_fifo.sv
// rvfpm_issue_fifo: synchronous FIFO with wrap-around pointers and a count.
//   ck/rst        : clock, synchronous active-high reset
//   push/wdata    : write (ignored when full)
//   pop/rdata     : read; rdata shows the head combinationally
//   full/empty    : status flags
// DEPTH must be a power of two so the pointers wrap naturally.
module rvfpm_issue_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/rvfpm_issue.sv
// rvfpm_issue: buffers F-extension instructions from the core, decodes
// register usage, holds back RAW hazards against in-flight rvfpm results and
// issues one instruction per cycle to rvfpm.
//   ck, rst        : clock, synchronous active-high reset
//   bus (slave)    : core handshake in, enable/instruction/data_fromXReg out
//   illegal_instr  : one-cycle pulse when the head entry is discarded
//   hazard_stall   : head is legal but blocked by the scoreboard
//   in_flight      : number of valid scoreboard slots
module rvfpm_issue
  import rvfpm_issue_pkg::*;
#(
  parameter int unsigned NUM_F_REGS      = 32,
  parameter int unsigned PIPELINE_STAGES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                  ck,
  input  logic                                  rst,
  rvfpm_issue_if.slave                          bus,
  output logic                                  illegal_instr,
  output logic                                  hazard_stall,
  output logic [$clog2(PIPELINE_STAGES+2)-1:0]  in_flight
);
  localparam int unsigned SB_SLOTS = PIPELINE_STAGES + 1;
  localparam int unsigned IFW      = $clog2(PIPELINE_STAGES + 2);

  logic [63:0] fifo_rdata;
  logic        fifo_full, fifo_empty;
  logic        push, pop, issue, drop, hazard;
  decoded_t    dec;
  sb_entry_t   sb_q [SB_SLOTS];
  sb_entry_t   sb_d [SB_SLOTS];

  logic        enable_q, enable_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] xdata_q, xdata_d;

  assign bus.instr_ready   = !fifo_full && !rst;
  assign push              = bus.instr_valid && bus.instr_ready;
  assign bus.enable        = enable_q;
  assign bus.instruction   = instr_q;
  assign bus.data_fromXReg = xdata_q;
  assign illegal_instr     = illegal_q;

  rvfpm_issue_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ck    (ck),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.data_fromXReg_in, bus.instruction_in}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    dec    = decode_instr(fifo_rdata[31:0], NUM_F_REGS);
    hazard = 1'b0;
    for (int unsigned i = 0; i < SB_SLOTS; i++) begin
      if (sb_q[i].valid && sb_q[i].writes_f &&
          ((dec.rs1F && dec.rs1 == sb_q[i].rd) ||
           (dec.rs2F && dec.rs2 == sb_q[i].rd) ||
           (dec.rs3F && dec.rs3 == sb_q[i].rd)))
        hazard = 1'b1;
    end
    issue        = !fifo_empty && dec.legal && !hazard;
    drop         = !fifo_empty && !dec.legal;
    pop          = issue || drop;
    hazard_stall = !fifo_empty && dec.legal && hazard;

    enable_d  = issue;
    illegal_d = drop;
    instr_d   = issue ? fifo_rdata[31:0]  : instr_q;
    xdata_d   = issue ? fifo_rdata[63:32] : xdata_q;

    // Slot 0 is loaded together with enable, so the producer is visible to
    // the hazard compare from its own enable cycle through PIPELINE_STAGES
    // cycles later.
    sb_d[0] = '0;
    if (issue) begin
      sb_d[0].valid    = 1'b1;
      sb_d[0].rd       = dec.rd;
      sb_d[0].writes_f = dec.rdF;
    end
    for (int unsigned i = 1; i < SB_SLOTS; i++) sb_d[i] = sb_q[i-1];

    in_flight = '0;
    for (int unsigned i = 0; i < SB_SLOTS; i++)
      in_flight = in_flight + IFW'(sb_q[i].valid);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      enable_q  <= 1'b0;
      illegal_q <= 1'b0;
      instr_q   <= '0;
      xdata_q   <= '0;
      for (int unsigned i = 0; i < SB_SLOTS; i++) sb_q[i] <= '0;
    end else begin
      enable_q  <= enable_d;
      illegal_q <= illegal_d;
      instr_q   <= instr_d;
      xdata_q   <= xdata_d;
      for (int unsigned i = 0; i < SB_SLOTS; i++) sb_q[i] <= sb_d[i];
    end
  end
endmodule

// File: tb/tb_rvfpm_issue.sv
// Directed bench for rvfpm_issue with a queue of expected issues.
module tb_rvfpm_issue;
  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       illegal_instr, hazard_stall;
  logic [2:0] in_flight;

  rvfpm_issue_if bus ();

  rvfpm_issue #(
    .NUM_F_REGS      (16),
    .PIPELINE_STAGES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .ck            (ck),
    .rst           (rst),
    .bus           (bus),
    .illegal_instr (illegal_instr),
    .hazard_stall  (hazard_stall),
    .in_flight     (in_flight)
  );

  always #5 ck = ~ck;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int hz_cnt   = 0;
  int ill_cnt  = 0;
  int acc_cyc  = 0;
  logic [63:0] exp_q [$];
  int          en_cyc_q [$];
  int          inf_q [$];

  always @(posedge ck) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: every issue is checked against the oldest expected entry.
  always @(negedge ck) begin
    logic [63:0] e;
    if (bus.enable === 1'b1) begin
      en_cnt++;
      en_cyc_q.push_back(cyc);
      inf_q.push_back(int'(in_flight));
      chk("issue_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_instr", bus.instruction, e[31:0]);
        chk("issue_xdata", bus.data_fromXReg, e[63:32]);
      end
    end
    if (hazard_stall === 1'b1) hz_cnt++;
    if (illegal_instr === 1'b1) ill_cnt++;
  end

  function automatic logic [31:0] fr(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] x, input bit expect_issue);
    bit ok, rdy;
    ok = 1'b0;
    bus.instr_valid      = 1'b1;
    bus.instruction_in   = ins;
    bus.data_fromXReg_in = x;
    for (int i = 0; i < 20; i++) begin
      rdy = bus.instr_ready;
      @(posedge ck);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.instr_valid = 1'b0;
    acc_cyc = cyc;
    if (ok && expect_issue) exp_q.push_back({x, ins});
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic clear_stats();
    en_cyc_q.delete();
    inf_q.delete();
    hz_cnt  = 0;
    ill_cnt = 0;
  endtask

  localparam logic [6:0] FADD = 7'b0000000;
  localparam logic [6:0] FSUB = 7'b0000100;
  localparam logic [6:0] FMUL = 7'b0001000;
  localparam logic [6:0] FSQ  = 7'b0101100;
  localparam logic [6:0] FMVX = 7'b1110000;

  initial begin
    int base, d0;
    logic [31:0] fadd_i;
    bus.instr_valid      = 1'b0;
    bus.instruction_in   = '0;
    bus.data_fromXReg_in = '0;

    // Reset state
    rst = 1'b1;
    tick(1);
    chk("ready_in_reset", 32'(bus.instr_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_enable", 32'(bus.enable), 32'd0);
    chk("rst_instruction", bus.instruction, 32'd0);
    chk("rst_xdata", bus.data_fromXReg, 32'd0);
    chk("rst_illegal", 32'(illegal_instr), 32'd0);
    chk("rst_hazard", 32'(hazard_stall), 32'd0);
    chk("rst_in_flight", 32'(in_flight), 32'd0);

    // Single FADD f3,f1,f2 into an idle block
    clear_stats();
    base   = en_cnt;
    fadd_i = fr(FADD, 5'd2, 5'd1, 5'd3);
    push(fadd_i, 32'h1234_5678, 1'b1);
    tick(8);
    chk("single_enable_count", 32'(en_cnt - base), 32'd1);
    d0 = (en_cyc_q.size() > 0) ? en_cyc_q[0] - acc_cyc : -1;
    chk("single_latency", 32'(d0), 32'd1);
    chk("hold_instruction", bus.instruction, fadd_i);
    chk("hold_xdata", bus.data_fromXReg, 32'h1234_5678);

    // FADD f3,f1,f2 then dependent FMUL f4,f3,f5
    tick(6);
    clear_stats();
    push(fr(FADD, 5'd2, 5'd1, 5'd3), 32'h0000_0011, 1'b1);
    push(fr(FMUL, 5'd5, 5'd3, 5'd4), 32'h0000_0022, 1'b1);
    tick(10);
    chk("raw_issue_count", 32'(en_cyc_q.size()), 32'd2);
    d0 = (en_cyc_q.size() == 2) ? en_cyc_q[1] - en_cyc_q[0] : -1;
    chk("raw_spacing", 32'(d0), 32'd6);
    chk("raw_stall_cycles", 32'(hz_cnt), 32'd5);

    // Independent FADD f3 then FSUB f6,f1,f2: back-to-back
    tick(6);
    clear_stats();
    push(fr(FADD, 5'd2, 5'd1, 5'd3), 32'h0000_0033, 1'b1);
    push(fr(FSUB, 5'd2, 5'd1, 5'd6), 32'h0000_0044, 1'b1);
    tick(4);
    chk("b2b_issue_count", 32'(en_cyc_q.size()), 32'd2);
    d0 = (en_cyc_q.size() == 2) ? en_cyc_q[1] - en_cyc_q[0] : -1;
    chk("b2b_spacing", 32'(d0), 32'd1);
    chk("b2b_in_flight_1", 32'((inf_q.size() > 0) ? inf_q[0] : -1), 32'd1);
    chk("b2b_in_flight_2", 32'((inf_q.size() > 1) ? inf_q[1] : -1), 32'd2);
    chk("b2b_no_stall", 32'(hz_cnt), 32'd0);

    // Illegal: integer ADD, then FSQRT with rs1=f20 (>= 16 registers)
    tick(6);
    clear_stats();
    base = en_cnt;
    push({7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 32'h0, 1'b0);
    push(fr(FSQ, 5'd0, 5'd20, 5'd3), 32'h0, 1'b0);
    tick(5);
    chk("illegal_pulses", 32'(ill_cnt), 32'd2);
    chk("illegal_no_enable", 32'(en_cnt - base), 32'd0);
    chk("illegal_drained_ready", 32'(bus.instr_ready), 32'd1);
    chk("illegal_no_stall", 32'(hazard_stall), 32'd0);

    // FMADD f8,f1,f2,f7 depends on FADD f7 through rs3
    tick(2);
    clear_stats();
    push(fr(FADD, 5'd2, 5'd1, 5'd7), 32'h0000_0055, 1'b1);
    push({5'd7, 2'b00, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1000011}, 32'h0000_0066, 1'b1);
    tick(10);
    chk("rs3_issue_count", 32'(en_cyc_q.size()), 32'd2);
    d0 = (en_cyc_q.size() == 2) ? en_cyc_q[1] - en_cyc_q[0] : -1;
    chk("rs3_spacing", 32'(d0), 32'd6);
    chk("rs3_stall_cycles", 32'(hz_cnt), 32'd5);

    // FMV.X.W x9,f1 writes an X register: reader of f9 is not stalled
    tick(6);
    clear_stats();
    push(fr(FMVX, 5'd0, 5'd1, 5'd9), 32'h0000_0077, 1'b1);
    push(fr(FADD, 5'd1, 5'd9, 5'd10), 32'h0000_0088, 1'b1);
    tick(4);
    chk("xrd_issue_count", 32'(en_cyc_q.size()), 32'd2);
    d0 = (en_cyc_q.size() == 2) ? en_cyc_q[1] - en_cyc_q[0] : -1;
    chk("xrd_spacing", 32'(d0), 32'd1);
    chk("xrd_no_stall", 32'(hz_cnt), 32'd0);

    // Reset mid-stall with a full FIFO
    tick(6);
    clear_stats();
    base = en_cnt;
    push(fr(FADD, 5'd2, 5'd1, 5'd3), 32'h0000_0099, 1'b1);
    push(fr(FMUL, 5'd5, 5'd3, 5'd4),  32'h1, 1'b0);
    push(fr(FMUL, 5'd5, 5'd3, 5'd11), 32'h2, 1'b0);
    push(fr(FMUL, 5'd5, 5'd3, 5'd12), 32'h3, 1'b0);
    push(fr(FMUL, 5'd5, 5'd3, 5'd13), 32'h4, 1'b0);
    chk("full_not_ready", 32'(bus.instr_ready), 32'd0);
    chk("full_stalled", 32'(hazard_stall), 32'd1);
    tick(1);
    chk("full_held_not_ready", 32'(bus.instr_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", 32'(bus.instr_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    #1;
    chk("midrst_in_flight", 32'(in_flight), 32'd0);
    chk("midrst_ready", 32'(bus.instr_ready), 32'd1);
    chk("midrst_enable", 32'(bus.enable), 32'd0);
    tick(12);
    chk("midrst_issue_count", 32'(en_cnt - base), 32'd1);
    chk("midrst_no_illegal", 32'(ill_cnt), 32'd0);
    chk("expected_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
